// File: rtl/buffer_pkg.sv
// Shared constants and helpers for the buffer family (row/pixel buffers and
// buffer_fifo_param). Count width is derived here so every user of a buffer
// agrees on how wide an occupancy count is.
package buffer_pkg;

  localparam int BUF_DATA_WIDTH_DEF = 8;
  localparam int BUF_DEPTH_DEF      = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // One extra bit so an occupancy count can reach DEPTH without wrapping.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/FlipFlopD_Habilitado.sv
// Generic enabled D register with asynchronous active-low reset.
module FlipFlopD_Habilitado #(
  parameter int BITS_EN_REGISTRO = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable_i,
  input  logic [BITS_EN_REGISTRO-1:0] d_i,
  output logic [BITS_EN_REGISTRO-1:0] q_o
);

  // Load d_i on enabled edges, clear asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        q_o <= '0;
    else if (enable_i) q_o <= d_i;
  end

endmodule

// File: rtl/buffer_ram_dp.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read.
// Contents are never reset; the FIFO pointers decide what is valid.
module buffer_ram_dp
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = BUF_DATA_WIDTH_DEF,
  parameter int DEPTH      = BUF_DEPTH_DEF,
  parameter int AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store write data on enabled edges.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/buffer_fifo_param.sv
// Parametrised FIFO buffer for the filter datapath.
// Gated write/read requests, full-range occupancy count, almost-full/empty
// flags, synchronous flush, sticky overflow/underflow and a one-cycle
// buffer_change pulse on every count change.
// Build option: define BUFFER_FIFO_FWFT_EN for show-ahead reads (head word
// presented combinationally, zero read latency); otherwise data_out is
// registered and updates on the accepting edge.
module buffer_fifo_param
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH      = BUF_DATA_WIDTH_DEF,
  parameter int DEPTH           = BUF_DEPTH_DEF,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2,
  localparam int AW             = clog2(DEPTH),
  localparam int CW             = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_req,
  input  logic                  write_en,
  input  logic                  read_req,
  input  logic                  read_en,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         data_in_buffer,
  output logic                  buffer_change,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH    = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH    = CW'(ALMOST_EMPTY_TH);

  logic                  wr, rd, wr_ok, rd_ok, ram_we;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, prev_count;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr    = write_req & write_en;
  assign rd    = read_req & read_en;
  assign rd_ok = rd & ~fifo_empty;
  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign wr_ok = wr & (~fifo_full | rd_ok);

  // Storage must not change during flush or while reset is held.
  assign ram_we = wr_ok & ~clear & reset;

  assign fifo_full      = (count_q == FULL_CNT);
  assign fifo_empty     = (count_q == '0);
  assign almost_full    = (count_q >= AF_TH);
  assign almost_empty   = (count_q <= AE_TH);
  assign data_in_buffer = count_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign buffer_change  = (count_q != prev_count);

  // Next-state for pointers, count and sticky errors; clear wins over traffic.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
      overflow_d  = overflow_q | (wr & ~wr_ok);
      underflow_d = underflow_q | (rd & ~rd_ok);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  FlipFlopD_Habilitado #(
    .BITS_EN_REGISTRO (CW)
  ) u_prev_count (
    .clk      (clk),
    .reset    (reset),
    .enable_i (1'b1),
    .d_i      (count_q),
    .q_o      (prev_count)
  );

  buffer_ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

`ifdef BUFFER_FIFO_FWFT_EN
  // Show-ahead: head word is visible whenever something is stored.
  assign data_out   = fifo_empty ? '0 : ram_rdata;
  assign data_valid = ~fifo_empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;

  // Capture the head word on the accepting edge; hold it otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else if (clear) begin
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_ok;
      if (rd_ok) data_out_q <= ram_rdata;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

endmodule
